// File: rtl/cdb_arbiter.sv
//============================================================================
// Module   : cdb_arbiter (with cdb_pkg)
// Brief    : Per-source FIFOs feeding a round-robin arbitrated, registered CDB.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package cdb_pkg;
  localparam int c_TAG_W = 6;
  localparam int c_RES_W = 32;

  typedef struct packed {
    logic               cdb_valid;
    logic               branch;
    logic [c_TAG_W-1:0] tag;
    logic [c_RES_W-1:0] result;
  } cdb_bfm;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  cdb_bfm           i_src_submit [N_SRC],
  output logic [N_SRC-1:0] o_src_stall,
  output cdb_bfm           o_cdb,
  output logic             o_overflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  cdb_bfm            r_mem  [N_SRC][DEPTH];
  logic [c_AW-1:0]   r_wptr [N_SRC];
  logic [c_AW-1:0]   r_rptr [N_SRC];
  logic [c_CW-1:0]   r_cnt  [N_SRC];
  logic [c_PW-1:0]   r_rr;

  logic [N_SRC-1:0]  w_push;
  logic [N_SRC-1:0]  w_full;
  logic [N_SRC-1:0]  w_cand;
  logic [N_SRC-1:0]  w_pop;
  logic [N_SRC-1:0]  w_wr;
  cdb_bfm            w_head [N_SRC];
  logic              w_gnt_vld;
  logic [c_PW-1:0]   w_gnt_idx;
  cdb_bfm            w_gnt_data;
  logic              w_drop;
  int                w_j;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign w_push[gi] = i_src_submit[gi].cdb_valid & ~flush;
      assign w_full[gi] = (r_cnt[gi] == c_CW'(DEPTH));
      // An empty FIFO competes with its same-cycle push (bypass through head).
      assign w_cand[gi] = ((r_cnt[gi] != '0) | w_push[gi]) & ~flush;
      assign w_head[gi] = (r_cnt[gi] != '0) ? r_mem[gi][r_rptr[gi]] : i_src_submit[gi];
      assign w_pop[gi]  = w_gnt_vld & (w_gnt_idx == c_PW'(gi));
      assign w_wr[gi]   = w_push[gi] & (~w_full[gi] | w_pop[gi]);
      assign o_src_stall[gi] = (c_CW'(DEPTH) - r_cnt[gi]) <= c_CW'(STALL_MARGIN);
    end
  endgenerate

  assign w_drop = |(w_push & w_full & ~w_pop);

  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    w_j        = 0;
    for (int k = 0; k < N_SRC; k++) begin
      w_j = (int'(r_rr) + k) % N_SRC;
      if (!w_gnt_vld && w_cand[w_j]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = c_PW'(w_j);
      end
    end
    if (w_gnt_vld) begin
      w_gnt_data           = w_head[w_gnt_idx];
      w_gnt_data.cdb_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_rr       <= '0;
      o_cdb      <= '0;
      o_overflow <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < N_SRC; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      o_cdb <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (w_wr[i])  r_wptr[i] <= r_wptr[i] + c_AW'(1);
        if (w_pop[i]) r_rptr[i] <= r_rptr[i] + c_AW'(1);
        r_cnt[i] <= r_cnt[i] + c_CW'(w_wr[i]) - c_CW'(w_pop[i]);
      end
      if (w_gnt_vld) r_rr <= c_PW'((int'(w_gnt_idx) + 1) % N_SRC);
      o_cdb <= w_gnt_data;
      if (w_drop) o_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (w_wr[i]) r_mem[i][r_wptr[i]] <= i_src_submit[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
//============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed and random checks of cdb_arbiter against a queue model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int c_N      = 4;
  localparam int c_DEPTH  = 8;
  localparam int c_MARGIN = 3;

  logic           clk;
  logic           rst_n;
  logic           flush;
  cdb_bfm         sub [c_N];
  logic [c_N-1:0] o_src_stall;
  cdb_bfm         o_cdb;
  logic           o_overflow;

  cdb_bfm         q [c_N][$];
  int             mp;
  logic           exp_ovf;
  cdb_bfm         exp_cdb;
  logic [c_N-1:0] exp_stall;
  int             n_assert;
  int             n_fail;

  cdb_arbiter #(.N_SRC(c_N), .DEPTH(c_DEPTH), .STALL_MARGIN(c_MARGIN)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .i_src_submit (sub),
    .o_src_stall  (o_src_stall),
    .o_cdb        (o_cdb),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  function automatic cdb_bfm mk(input logic v, input logic b, input logic [5:0] t,
                                input logic [31:0] r);
    cdb_bfm e;
    e.cdb_valid = v;
    e.branch    = b;
    e.tag       = t;
    e.result    = r;
    return e;
  endfunction

  task automatic idle();
    for (int i = 0; i < c_N; i++) sub[i] = mk(1'b0, 1'($urandom), 6'($urandom), $urandom);
    flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < c_N; i++) q[i].delete();
    mp        = 0;
    exp_ovf   = 1'b0;
    exp_cdb   = '0;
    exp_stall = '0;
  endtask

  // Queue-level view: winner is first non-empty-or-submitting source from mp.
  task automatic model_step();
    int g;
    g = -1;
    if (flush) begin
      for (int i = 0; i < c_N; i++) q[i].delete();
      exp_cdb = '0;
    end else begin
      for (int k = 0; k < c_N; k++) begin
        int j;
        j = (mp + k) % c_N;
        if (g < 0 && (q[j].size() > 0 || sub[j].cdb_valid)) g = j;
      end
      for (int i = 0; i < c_N; i++) begin
        if (sub[i].cdb_valid) begin
          if (q[i].size() < c_DEPTH || g == i) q[i].push_back(sub[i]);
          else exp_ovf = 1'b1;
        end
      end
      if (g >= 0) begin
        exp_cdb = q[g].pop_front();
        mp      = (g + 1) % c_N;
      end else begin
        exp_cdb = '0;
      end
    end
    for (int i = 0; i < c_N; i++) exp_stall[i] = ((c_DEPTH - q[i].size()) <= c_MARGIN);
  endtask

  task automatic check_now(input string tagn);
    n_assert++;
    assert (o_cdb === exp_cdb) else begin
      n_fail++;
      $error("FAIL %s o_cdb observed=%h expected=%h", tagn, o_cdb, exp_cdb);
    end
    n_assert++;
    assert (o_overflow === exp_ovf) else begin
      n_fail++;
      $error("FAIL %s o_overflow observed=%b expected=%b", tagn, o_overflow, exp_ovf);
    end
    n_assert++;
    assert (o_src_stall === exp_stall) else begin
      n_fail++;
      $error("FAIL %s o_src_stall observed=%b expected=%b", tagn, o_src_stall, exp_stall);
    end
  endtask

  task automatic step(input string tagn);
    model_step();
    @(posedge clk);
    #1;
    check_now(tagn);
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    n_assert = 0;
    n_fail   = 0;
    idle();
    model_reset();
    #12;
    check_now("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Collision straight after reset: tags 1..4 in source order.
    for (int i = 0; i < c_N; i++) sub[i] = mk(1'b1, 1'b0, 6'(i + 1), 32'(100 + i));
    step("collide");
    n_assert++;
    assert (o_cdb.tag === 6'd1) else begin
      n_fail++;
      $error("FAIL collide_first tag observed=%0d expected=1", o_cdb.tag);
    end
    idle();
    repeat (4) step("collide_drain");

    // Single submission from src1.
    sub[1] = mk(1'b1, 1'b0, 6'd5, 32'h0000_0030);
    step("single");
    n_assert++;
    assert (o_cdb.cdb_valid === 1'b1 && o_cdb.tag === 6'd5 && o_cdb.result === 32'h30) else begin
      n_fail++;
      $error("FAIL single_direct observed=%h expected tag=5 result=30", o_cdb);
    end
    idle();
    step("single_t2");

    // Fairness: src0 every cycle, src2 once.
    for (int c = 0; c < 8; c++) begin
      idle();
      sub[0] = mk(1'b1, 1'($urandom), 6'(c + 10), $urandom);
      if (c == 0) sub[2] = mk(1'b1, 1'b1, 6'd33, 32'hCAFE_0002);
      step("fair");
    end
    idle();
    repeat (6) step("fair_drain");

    // Back-pressure and overflow: all sources flood, src3 fills and drops.
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < c_N; i++) sub[i] = mk(1'b1, 1'($urandom), 6'(i * 16 + c), $urandom);
      flush = 1'b0;
      step("flood");
    end
    n_assert++;
    assert (o_overflow === 1'b1) else begin
      n_fail++;
      $error("FAIL flood_overflow observed=%b expected=1", o_overflow);
    end
    idle();
    repeat (40) step("flood_drain");

    // Flush with entries buffered and a same-cycle submission.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < c_N; i++) sub[i] = mk(1'b1, 1'b0, 6'(40 + c), $urandom);
      step("pre_flush");
    end
    idle();
    flush  = 1'b1;
    sub[2] = mk(1'b1, 1'b0, 6'd62, 32'hDEAD_BEEF);
    step("flush");
    idle();
    repeat (4) step("post_flush");

    // Random traffic with occasional flushes.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < c_N; i++)
        sub[i] = mk(1'($urandom_range(99) < 40), 1'($urandom), 6'($urandom), $urandom);
      flush = 1'($urandom_range(99) < 3);
      step("random");
    end

    // Asynchronous reset mid-burst.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < c_N; i++) sub[i] = mk(1'b1, 1'b0, 6'(50 + c), $urandom);
      step("pre_reset");
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_now("reset_async");
    @(posedge clk);
    #1;
    check_now("reset_held");
    rst_n = 1'b1;
    repeat (5) step("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
